// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone master adapter.
package wb_pkg;

    typedef enum logic [1:0] {
        WBM_IDLE,
        WBM_REQ,
        WBM_WAIT
    } wb_master_state_e;

    localparam int WB_DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Transfer watchdog: counts busy cycles and flags the cycle in which the
// count would reach TIMEOUT_CYCLES. Built only with WB_MASTER_TIMEOUT_EN.
module wb_timeout_ctr
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_DEFAULT_TIMEOUT
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the edge that would bring the count to TIMEOUT_CYCLES.
    assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_master_adapter.sv
// Native request/response to Wishbone B4 pipelined master, one transfer in flight.
// Optional transfer timeout is compiled in with WB_MASTER_TIMEOUT_EN.
module wb_master_adapter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = WB_DEFAULT_TIMEOUT
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i
);

    // Native handshake: a request transfers on a cycle where req_valid and
    // req_ready are both high; the response is a single rsp_valid pulse
    // with no backpressure.

    wb_master_state_e state;
    logic             accept;
    logic             busy;
    logic             slave_done;
    logic             timeout_hit;

    assign req_ready  = (state == WBM_IDLE);
    assign accept     = req_ready && req_valid;
    assign busy       = (state == WBM_REQ) || (state == WBM_WAIT);
    assign slave_done = busy && (wb_ack_i || wb_err_i);

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear    (accept),
        .run      (busy),
        .expired  (timeout_hit)
    );
`else
    // Without the watchdog a transfer waits for the slave indefinitely.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= WBM_IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                WBM_IDLE: begin
                    if (accept) begin
                        wb_adr_o <= req_addr;
                        wb_dat_o <= req_wdata;
                        wb_we_o  <= req_we;
                        wb_sel_o <= req_be;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= WBM_REQ;
                    end
                end
                WBM_REQ, WBM_WAIT: begin
                    if (slave_done || timeout_hit) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        rsp_valid <= 1'b1;
                        // err wins over ack; no ack and no err means timeout.
                        rsp_err   <= wb_err_i || !wb_ack_i;
                        rsp_rdata <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
                        state     <= WBM_IDLE;
                    end else if (state == WBM_REQ && !wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= WBM_WAIT;
                    end
                end
                default: state <= WBM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_adapter.sv
// Self-checking bench for wb_master_adapter: transaction-level timing model
// plus per-cycle compare of bus and response outputs.
module tb_wb_master_adapter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int T  = 8;
    localparam int unsigned NEVER = 1000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_we = 1'b0;
    logic [BW-1:0] req_be = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_we_o;
    logic [BW-1:0] wb_sel_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;
    logic          wb_stall_i = 1'b0;

    wb_master_adapter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_stall_i(wb_stall_i)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- model state ----------------
    typedef struct {
        int unsigned   start;
        int unsigned   stb_end;
        int unsigned   cyc_end;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [BW-1:0] sel;
        logic          we;
    } bus_t;

    typedef struct {
        int unsigned   at;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    int unsigned   acc_n;
    int unsigned   last_rsp_at;
    logic          last_rsp_err;
    logic [DW-1:0] last_rsp_rdata;
    logic [AW-1:0] seen_adr;
    logic [DW-1:0] seen_dat;
    int            stb_cnt;
    int            cyc_cnt;
    int            n_rsp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            logic exp_cyc;
            logic exp_stb;
            while (bus_q.size() > 0 && bus_q[0].cyc_end < cycle) void'(bus_q.pop_front());
            exp_cyc = (bus_q.size() > 0) && (bus_q[0].start <= cycle);
            exp_stb = exp_cyc && (cycle <= bus_q[0].stb_end);
            chk("cyc", wb_cyc_o, exp_cyc);
            chk("stb", wb_stb_o, exp_stb);
            chk("req_ready", req_ready, !exp_cyc);
            if (exp_stb) begin
                chk("adr", wb_adr_o, bus_q[0].adr);
                chk("dat", wb_dat_o, bus_q[0].dat);
                chk("sel", wb_sel_o, bus_q[0].sel);
                chk("we", wb_we_o, bus_q[0].we);
            end
            if (!exp_cyc) chk("we_idle", wb_we_o, 1'b0);
            if (wb_stb_o) begin
                stb_cnt++;
                seen_adr = wb_adr_o;
                seen_dat = wb_dat_o;
            end
            if (wb_cyc_o) cyc_cnt++;

            if (exp_q.size() > 0 && exp_q[0].at < cycle) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_missing @cycle %0d: got none expected rsp at %0d", cycle, exp_q[0].at);
                void'(exp_q.pop_front());
            end
            if (rsp_valid) begin
                n_rsp++;
                last_rsp_at    = cycle;
                last_rsp_err   = rsp_err;
                last_rsp_rdata = rsp_rdata;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected @cycle %0d: got rsp_valid=1 expected 0", cycle);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_at", cycle, e.at);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // kind: 0 ack, 1 err, 2 ack+err, 3 no response. The slave answers in strobe-
    // relative cycle d and holds stall for the first s cycles.
    task automatic do_xfer(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic we,
                           input logic [BW-1:0] be, input int s, input int d, input int kind,
                           input bit keep);
        logic [DW-1:0] rd;
        int unsigned   r;
        bit            timed;
        bit            noresp;
        bus_t          b;
        rsp_t          p;
        rd        = $urandom;
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_we    = we;
        req_be    = be;
        @(posedge clk); #1;
        acc_n     = cycle;
        req_valid = keep;
        stb_cnt   = 0;
        cyc_cnt   = 0;

        r      = d;
        timed  = 1'b0;
        noresp = (kind == 3);
`ifdef WB_MASTER_TIMEOUT_EN
        if (noresp || r + 1 > T) begin
            timed  = 1'b1;
            noresp = 1'b0;
            r      = T - 1;
        end
`endif
        b.start   = acc_n;
        b.cyc_end = noresp ? acc_n + NEVER : acc_n + r;
        b.stb_end = acc_n + umin(noresp ? NEVER : r, s);
        b.adr = a; b.dat = wd; b.sel = be; b.we = we;
        bus_q.push_back(b);
        if (!noresp) begin
            p.at    = acc_n + r + 1;
            p.err   = timed || (kind != 0);
            p.rdata = (!timed && kind == 0 && !we) ? rd : '0;
            exp_q.push_back(p);
        end

        for (int k = 0; k <= d; k++) begin
            wb_stall_i = (k < s);
            wb_ack_i   = (k == d) && (kind == 0 || kind == 2);
            wb_err_i   = (k == d) && (kind == 1 || kind == 2);
            wb_dat_i   = (k == d) ? rd : DW'($urandom);
            @(posedge clk); #1;
        end
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
    endtask

    // Idle cycles with random slave noise, which an idle adapter must ignore.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            wb_ack_i   = 1'($urandom_range(0, 1));
            wb_err_i   = 1'($urandom_range(0, 1));
            wb_stall_i = 1'($urandom_range(0, 1));
            wb_dat_i   = $urandom;
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
    endtask

    task automatic abort_reset();
        int unsigned rr;
        rst = 1'b1;
        @(posedge clk); #1;
        rr  = cycle;
        rst = 1'b0;
        if (bus_q.size() > 0 && bus_q[bus_q.size()-1].cyc_end >= rr) begin
            bus_q[bus_q.size()-1].cyc_end = rr - 1;
            bus_q[bus_q.size()-1].stb_end = umin(bus_q[bus_q.size()-1].stb_end, rr - 1);
        end
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].at >= rr) void'(exp_q.pop_back());
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rsp_before;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checking = 1'b1;
        settle();
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);

        // Write, slave acks one cycle after strobe.
        do_xfer(32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 0, 1, 0, 1'b0);
        settle();
        chk("w_latency", last_rsp_at - acc_n, 2);
        chk("w_stb_cycles", stb_cnt, 1);
        chk("w_adr", seen_adr, 32'h10);
        chk("w_dat", seen_dat, 32'hDEADBEEF);
        chk("w_err", last_rsp_err, 0);
        chk("w_rdata", last_rsp_rdata, 0);

        // Read with stall held three cycles, ack as stall drops.
        idle(2);
        do_xfer(32'h14, 32'h0, 1'b0, 4'hF, 3, 3, 0, 1'b0);
        settle();
        chk("r_stb_cycles", stb_cnt, 4);
        chk("r_latency", last_rsp_at - acc_n, 4);
        chk("r_err", last_rsp_err, 0);

        // Read answered with ack and err together.
        do_xfer(32'h18, 32'h0, 1'b0, 4'h3, 0, 1, 2, 1'b0);
        settle();
        chk("ae_err", last_rsp_err, 1);
        chk("ae_rdata", last_rsp_rdata, 0);

        // Reset while waiting for a slave that never answers.
        rsp_before = n_rsp;
        do_xfer(32'h20, 32'h1234, 1'b0, 4'hF, 0, 3, 3, 1'b0);
        abort_reset();
        settle();
        chk("abort_no_rsp", n_rsp - rsp_before, 0);
        do_xfer(32'h24, 32'h5555AAAA, 1'b1, 4'hC, 1, 2, 0, 1'b0);
        settle();
        chk("after_abort_err", last_rsp_err, 0);

        // Back-to-back writes with req_valid held high.
        rsp_before = n_rsp;
        do_xfer(32'h100, 32'h11111111, 1'b1, 4'hF, 0, 0, 0, 1'b1);
        do_xfer(32'h104, 32'h22222222, 1'b1, 4'h5, 1, 2, 0, 1'b0);
        settle();
        chk("b2b_rsp_count", n_rsp - rsp_before, 2);

        // Slave that never responds.
        rsp_before = n_rsp;
        do_xfer(32'h200, 32'h0, 1'b0, 4'hF, 0, 100, 3, 1'b0);
        settle();
`ifdef WB_MASTER_TIMEOUT_EN
        chk("to_latency", last_rsp_at - acc_n, T);
        chk("to_err", last_rsp_err, 1);
        chk("to_cyc_cycles", cyc_cnt, T);
        chk("to_rsp_count", n_rsp - rsp_before, 1);
`else
        chk("hang_cyc_100", cyc_cnt >= 100, 1);
        chk("hang_rsp_count", n_rsp - rsp_before, 0);
`endif
        abort_reset();

        // Randomized transfers, answer index up to T-1 (same-cycle timeout boundary).
        for (int i = 0; i < 60; i++) begin
            idle($urandom_range(0, 2));
            do_xfer($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, T - 1), $urandom_range(0, 2), 1'b0);
        end
        settle();
        settle();
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_master_adapter.md
Name: wb_master_adapter

Overview:
Generic Wishbone B4 pipelined master adapter. Converts a simple native request/response bus into single Wishbone transactions with one outstanding transfer at a time. Sits between an internal initiator (DMA engine, test sequencer, CPU-side bridge) and a Wishbone interconnect or slave adapter.

Parameters:
ADDR_WIDTH, 32, address width of the native and Wishbone buses.
DATA_WIDTH, 32, data width; must be a multiple of 8.
TIMEOUT_CYCLES, 256, maximum cycles from strobe to ack/err before a forced error response (used only when the optional feature is compiled in); must be at least 2.

Ports:
wb_clk_i  in  1  clock, rising edge
wb_rst_i  in  1  reset, synchronous, active-high
req_valid  in  1  native request valid
req_ready  out  1  adapter can accept a request
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
req_we  in  1  1 = write, 0 = read
req_be  in  DATA_WIDTH/8  byte enables
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data
rsp_err  out  1  transfer terminated with an error
wb_adr_o  out  ADDR_WIDTH  Wishbone address
wb_dat_o  out  DATA_WIDTH  Wishbone write data
wb_dat_i  in  DATA_WIDTH  Wishbone read data
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select
wb_stb_o  out  1  Wishbone strobe
wb_cyc_o  out  1  Wishbone cycle
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
wb_stall_i  in  1  Wishbone stall

Behaviour:
- One clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high. All outputs are registered except req_ready, which is decoded from the state.
- Reset values: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid and rsp_err are 0; wb_adr_o, wb_dat_o, wb_sel_o and rsp_rdata are all zeros.
- FSM has three states: IDLE, REQ and WAIT.
- IDLE: req_ready=1. On req_valid, latch addr/wdata/we/be into wb_*_o, set cyc=stb=1, and go to REQ.
- REQ: cyc=stb=1, and the outputs hold stable.
  - If ack_i or err_i is sampled, the transfer completes, regardless of stall.
  - Otherwise, if stall_i=0, drop stb and go to WAIT.
  - Otherwise, stay in REQ.
- WAIT: cyc=1, stb=0. On ack_i or err_i, the transfer completes.
- Completion, at the same clock edge:
  - Set cyc=stb=0 and we_o=0.
  - Pulse rsp_valid=1 for exactly one cycle.
  - Set rsp_err=err_i.
  - For a read with ack, rsp_rdata=wb_dat_i. For a write or an error, rsp_rdata=0.
  - Return to IDLE.
- If ack_i and err_i are sampled together, err wins: rsp_err=1 and rsp_rdata=0.
- req_ready=0 in REQ and WAIT. A new request is accepted no earlier than the cycle in which rsp_valid is high, which is IDLE again. Back-to-back requests therefore deassert cyc for at least one cycle between transfers.
- The response bus has no backpressure; the initiator must sample rsp_valid.
- Latency: request accepted at edge N, stb high from N. A slave that acks in the first strobe cycle gives rsp_valid at N+1. A slave with one wait state gives ack at N+1 and rsp_valid at N+2.
- ack_i or err_i while in IDLE is ignored.
- A reset in REQ or WAIT forces cyc=stb=0 at that edge. No rsp_valid is produced for the aborted transfer.

Optional Feature:
WB_MASTER_TIMEOUT_EN.
- Defined: a counter clears when the adapter leaves IDLE and increments in REQ and WAIT. When it reaches TIMEOUT_CYCLES with no ack/err, the adapter terminates: cyc=stb=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, and it returns to IDLE. An ack/err arriving in the same cycle as the timeout completes normally.
- Undefined: no counter exists, and the adapter waits indefinitely.

Decomposition:
- Package wb_pkg holds:
  - typedef enum logic [1:0] wb_master_state_e {WBM_IDLE, WBM_REQ, WBM_WAIT};
  - localparam int WB_DEFAULT_TIMEOUT = 256.
- Sub-module wb_timeout_ctr (parameter TIMEOUT_CYCLES; ports clear, run, expired) holds the counter. It is instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- Single write, req addr=0x10, wdata=0xDEADBEEF, be=0xF, to a slave that acks one cycle after stb → exactly one cycle with stb=1 and that adr/dat/sel/we; rsp_valid at N+2; rsp_err=0; rsp_rdata=0.
- Read of 0x14, where the slave returns 0xCAFEF00D after stall held for 3 cycles → stb stays high for 4 cycles; rsp_rdata=0xCAFEF00D; req_ready=0 throughout.
- Read answered with err_i=1 and ack_i=1 in the same cycle → rsp_valid=1, rsp_err=1, rsp_rdata=0; cyc=0 on the next cycle.
- Reset asserted in WAIT with a held ack never arriving → cyc=stb=0 at the reset edge; no rsp_valid; the next request after reset completes normally.
- Back-to-back: req_valid held high for 2 writes → cyc is low for at least 1 cycle between transfers; 2 rsp_valid pulses; each transfer's data is correct.
- With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave that never responds → rsp_valid and rsp_err=1 exactly 8 cycles after stb rises; cyc drops. Without the macro, cyc remains high for 100 cycles.
